r88_fetch: RTL and testbench
============================

Name: r88_fetch

Overview:
Instruction fetch unit for the Rocket88 core, directly upstream of the instruction decoder. It owns the 16-bit program counter and issues byte reads on the memory bus with a wait-state handshake. Fetched bytes go into a small prefetch FIFO, which feeds the decoder's intD input through a valid/take handshake. The decoder redirects fetch (branch, jump, interrupt vector) through a PC-load port that flushes the queue.

Parameters:
DEPTH, 4, prefetch FIFO entries (power of two, 2..16)
RESET_VECTOR, 16'h0000, PC value loaded on reset

Ports:
sysClock  input  1  system clock, all state on rising edge
nReset  input  1  asynchronous active-low reset
memAddr  output  16  fetch address
memRead  output  1  fetch request
memData  input  8  read data, valid when memReady=1
memReady  input  1  current read completes at this edge
instrByte  output  8  head-of-queue byte (decoder intD)
instrPc  output  16  address of instrByte
instrValid  output  1  queue non-empty
instrTake  input  1  decoder consumes head this edge
loadPc  input  1  redirect fetch, flush queue
newPc  input  16  redirect target
halt  input  1  stop issuing new fetches

Behaviour:
- Reset (nReset=0, asynchronous): pc=RESET_VECTOR, FIFO empty, state IDLE. memRead=0, memAddr=RESET_VECTOR, instrValid=0, instrByte=0, instrPc=0. A reset mid-read abandons the bus cycle.
- States:
  - IDLE: no read outstanding.
  - READ: read outstanding, data kept.
  - DISCARD: read outstanding, data dropped.
- Issue rule: in IDLE, if halt=0 and count<DEPTH and loadPc=0, go to READ next edge. memAddr=pc, memRead=1 from that cycle.
- Bus rule: memRead and memAddr are registered. Once asserted, they stay stable until an edge where memReady=1, regardless of halt. memReady while memRead=0 is ignored.
- Completion in READ (memReady=1):
  - Push {memData, pc} into the FIFO; pc increments by 1 (FFFF wraps to 0000).
  - If the issue condition still holds (halt=0, count after this edge <DEPTH, loadPc=0), stay in READ with memAddr=pc+1 (back-to-back, no bubble). Otherwise go to IDLE and drop memRead.
- Latency: a zero-wait read issued at cycle t (memReady=1 at t) gives instrValid=1 at t+1. Sustained throughput is 1 byte/cycle.
- FIFO:
  - instrByte/instrPc/instrValid are the registered head.
  - instrTake with instrValid=1 pops at the edge. instrTake with instrValid=0 is ignored.
  - Simultaneous push and pop leaves count unchanged.
  - Full (count=DEPTH) blocks issue. Overflow cannot occur because issue requires count<DEPTH and only one read is outstanding.
- loadPc=1 at an edge:
  - Always: FIFO cleared (instrValid=0 next cycle), pc=newPc.
  - In IDLE: next state IDLE; issue may start on the following edge.
  - In READ with memReady=0: go to DISCARD and keep the bus request stable.
  - In READ with memReady=1: drop the returning byte; go to IDLE.
  - In DISCARD: pc is updated, stay in DISCARD.
  - loadPc overrides a simultaneous instrTake and a simultaneous push.
- DISCARD with memReady=1: data dropped, pc unchanged (already newPc), go to IDLE.
- halt=1: no new issue. An outstanding read completes normally. The queue keeps draining through instrTake.

Test Plan:
- Reset then zero-wait memory (memReady tied 1, mem[a]=a[7:0]), instrTake=0 → memAddr 0000,0001,0002,0003 on consecutive cycles. memRead drops when count=4. instrByte=00, instrPc=0000, instrValid=1.
- One-wait memory (memReady every second cycle), instrTake=1 continuously → memAddr held 2 cycles per byte. Decoder sees 00,01,02,… with no duplicates or drops.
- Full queue (4 entries), pulse instrTake for 1 cycle → next fetch 0004 issues; count returns to 4; head becomes 01.
- Read of 0005 outstanding with memReady=0; loadPc=1, newPc=8000 → state DISCARD, memAddr stays 0005 until memReady. That byte is dropped. Next fetch is 8000; the first instrByte after the flush has instrPc=8000.
- loadPc newPc=FFFE, zero-wait memory → instrPc sequence FFFE, FFFF, 0000, 0001 (wraps).
- halt=1 asserted during a wait-stated read → read completes and its byte is queued. No further memRead until halt=0. nReset pulsed low mid-read → memRead=0 and instrValid=0 immediately, with no clock edge needed.

Source files
------------

// File: rtl/r88_fetch.sv
// Rocket88 fetch: registered byte-read bus master feeding a DEPTH-entry prefetch queue; a zero-wait read shows at instrValid one cycle later.
// Stalls issue when the queue is full or halt is set; loadPc flushes the queue and discards any in-flight byte.
module r88_fetch #(
  parameter int          DEPTH        = 4,
  parameter logic [15:0] RESET_VECTOR = 16'h0000
) (
  input  logic        sysClock,
  input  logic        nReset,
  output logic [15:0] memAddr,
  output logic        memRead,
  input  logic [7:0]  memData,
  input  logic        memReady,
  output logic [7:0]  instrByte,
  output logic [15:0] instrPc,
  output logic        instrValid,
  input  logic        instrTake,
  input  logic        loadPc,
  input  logic [15:0] newPc,
  input  logic        halt
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DISCARD} state_t;

  state_t          r_state;
  state_t          w_next;
  logic [15:0]     r_pc;
  logic [15:0]     r_addr;
  logic [7:0]      r_byte [DEPTH];
  logic [15:0]     r_epc  [DEPTH];
  logic [AW-1:0]   r_rd;
  logic [AW-1:0]   r_wr;
  logic [CW-1:0]   r_count;
  logic [CW-1:0]   w_count_next;
  logic            w_done;
  logic            w_push;
  logic            w_pop;
  logic            w_issue_idle;
  logic            w_issue_bb;

  assign w_done       = (r_state == S_READ) && memReady;
  assign w_push       = w_done && !loadPc;
  assign w_pop        = instrTake && (r_count != '0);
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);
  assign w_issue_idle = !halt && !loadPc && (r_count < CW'(DEPTH));
  // Back-to-back issue looks at the occupancy after this edge's push/pop.
  assign w_issue_bb   = !halt && !loadPc && (w_count_next < CW'(DEPTH));

  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_issue_idle) w_next = S_READ;
      S_READ: begin
        if (memReady)    w_next = w_issue_bb ? S_READ : S_IDLE;
        else if (loadPc) w_next = S_DISCARD;
      end
      S_DISCARD: if (memReady) w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    memRead = (r_state != S_IDLE);
    memAddr = r_addr;
  end

  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      r_pc   <= RESET_VECTOR;
      r_addr <= RESET_VECTOR;
    end else begin
      if (loadPc)      r_pc <= newPc;
      else if (w_done) r_pc <= r_pc + 16'd1;
      if (r_state == S_IDLE && w_next == S_READ)
        r_addr <= r_pc;
      else if (w_done && w_next == S_READ)
        r_addr <= r_pc + 16'd1;
    end
  end

  // Flush wins over both a simultaneous push and pop.
  always_ff @(posedge sysClock or negedge nReset) begin
    if (!nReset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_byte[i] <= 8'h00;
        r_epc[i]  <= 16'h0000;
      end
    end else if (loadPc) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_byte[r_wr] <= memData;
        r_epc[r_wr]  <= r_pc;
        r_wr         <= r_wr + 1'b1;
      end
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_count <= w_count_next;
    end
  end

  assign instrValid = (r_count != '0);
  assign instrByte  = r_byte[r_rd];
  assign instrPc    = r_epc[r_rd];

endmodule

// File: tb/tb_r88_fetch.sv
// Directed bench for r88_fetch: memory returns mem[a] = a[7:0]; expectations are hand-derived cycle by cycle.
module tb_r88_fetch;

  logic        sysClock;
  logic        nReset;
  logic [15:0] memAddr;
  logic        memRead;
  logic [7:0]  memData;
  logic        memReady;
  logic [7:0]  instrByte;
  logic [15:0] instrPc;
  logic        instrValid;
  logic        instrTake;
  logic        loadPc;
  logic [15:0] newPc;
  logic        halt;

  int checks   = 0;
  int failures = 0;

  r88_fetch #(.DEPTH(4), .RESET_VECTOR(16'h0000)) dut (
    .sysClock(sysClock), .nReset(nReset),
    .memAddr(memAddr), .memRead(memRead), .memData(memData), .memReady(memReady),
    .instrByte(instrByte), .instrPc(instrPc), .instrValid(instrValid), .instrTake(instrTake),
    .loadPc(loadPc), .newPc(newPc), .halt(halt)
  );

  assign memData = memAddr[7:0];

  initial sysClock = 1'b0;
  always #5 sysClock = ~sysClock;

  task automatic step;
    @(posedge sysClock);
    #1;
  endtask

  task automatic test_reset;
    nReset = 1'b0; memReady = 1'b0; instrTake = 1'b0; loadPc = 1'b0; newPc = 16'h0; halt = 1'b0;
    step(); step();
    checks++; if (memRead !== 1'b0)      begin failures++; $display("FAIL reset_memRead got=%b exp=0", memRead); end
    checks++; if (memAddr !== 16'h0000)  begin failures++; $display("FAIL reset_memAddr got=%h exp=0000", memAddr); end
    checks++; if (instrValid !== 1'b0)   begin failures++; $display("FAIL reset_instrValid got=%b exp=0", instrValid); end
    checks++; if (instrByte !== 8'h00)   begin failures++; $display("FAIL reset_instrByte got=%h exp=00", instrByte); end
    checks++; if (instrPc !== 16'h0000)  begin failures++; $display("FAIL reset_instrPc got=%h exp=0000", instrPc); end
    nReset = 1'b1;
  endtask

  task automatic test_zero_wait;
    logic [15:0] e;
    memReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      e = 16'(i);
      checks++; if (memRead !== 1'b1) begin failures++; $display("FAIL zw_memRead[%0d] got=%b exp=1", i, memRead); end
      checks++; if (memAddr !== e)    begin failures++; $display("FAIL zw_memAddr[%0d] got=%h exp=%h", i, memAddr, e); end
      checks++; if (instrValid !== (i > 0)) begin failures++; $display("FAIL zw_valid[%0d] got=%b exp=%b", i, instrValid, (i > 0)); end
    end
    step();
    checks++; if (memRead !== 1'b0)     begin failures++; $display("FAIL zw_full_stop got=%b exp=0", memRead); end
    checks++; if (instrValid !== 1'b1)  begin failures++; $display("FAIL zw_head_valid got=%b exp=1", instrValid); end
    checks++; if (instrByte !== 8'h00)  begin failures++; $display("FAIL zw_head_byte got=%h exp=00", instrByte); end
    checks++; if (instrPc !== 16'h0000) begin failures++; $display("FAIL zw_head_pc got=%h exp=0000", instrPc); end
  endtask

  task automatic test_full_pop;
    instrTake = 1'b1;
    step();
    instrTake = 1'b0;
    checks++; if (instrByte !== 8'h01)  begin failures++; $display("FAIL fp_head_byte got=%h exp=01", instrByte); end
    checks++; if (instrPc !== 16'h0001) begin failures++; $display("FAIL fp_head_pc got=%h exp=0001", instrPc); end
    step();
    checks++; if (memRead !== 1'b1 || memAddr !== 16'h0004) begin failures++; $display("FAIL fp_refetch got=%b/%h exp=1/0004", memRead, memAddr); end
    step();
    checks++; if (memRead !== 1'b0) begin failures++; $display("FAIL fp_refull got=%b exp=0", memRead); end
    step(); step();
    checks++; if (memRead !== 1'b0 || instrPc !== 16'h0001) begin failures++; $display("FAIL fp_hold got=%b/%h exp=0/0001", memRead, instrPc); end
  endtask

  task automatic test_discard;
    memReady = 1'b0; instrTake = 1'b1;
    step();
    instrTake = 1'b0;
    step();
    checks++; if (memRead !== 1'b1 || memAddr !== 16'h0005) begin failures++; $display("FAIL dc_issue got=%b/%h exp=1/0005", memRead, memAddr); end
    loadPc = 1'b1; newPc = 16'h8000;
    step();
    loadPc = 1'b0;
    checks++; if (memRead !== 1'b1 || memAddr !== 16'h0005) begin failures++; $display("FAIL dc_bus_hold got=%b/%h exp=1/0005", memRead, memAddr); end
    checks++; if (instrValid !== 1'b0) begin failures++; $display("FAIL dc_flush got=%b exp=0", instrValid); end
    step(); step();
    checks++; if (memRead !== 1'b1 || memAddr !== 16'h0005) begin failures++; $display("FAIL dc_bus_hold2 got=%b/%h exp=1/0005", memRead, memAddr); end
    memReady = 1'b1;
    step();
    checks++; if (memRead !== 1'b0 || instrValid !== 1'b0) begin failures++; $display("FAIL dc_drop got=%b/%b exp=0/0", memRead, instrValid); end
    step();
    checks++; if (memRead !== 1'b1 || memAddr !== 16'h8000) begin failures++; $display("FAIL dc_redirect got=%b/%h exp=1/8000", memRead, memAddr); end
    step();
    checks++; if (instrValid !== 1'b1 || instrPc !== 16'h8000 || instrByte !== 8'h00) begin
      failures++; $display("FAIL dc_first got=%b/%h/%h exp=1/8000/00", instrValid, instrPc, instrByte); end
  endtask

  task automatic test_wrap;
    logic [15:0] exp_pc [4];
    exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    loadPc = 1'b1; newPc = 16'hFFFE;
    step();
    loadPc = 1'b0;
    checks++; if (memRead !== 1'b0 || instrValid !== 1'b0) begin failures++; $display("FAIL wr_flush got=%b/%b exp=0/0", memRead, instrValid); end
    for (int i = 0; i < 5; i++) step();
    checks++; if (memRead !== 1'b0) begin failures++; $display("FAIL wr_full got=%b exp=0", memRead); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (instrValid !== 1'b1 || instrPc !== exp_pc[i] || instrByte !== exp_pc[i][7:0]) begin
        failures++; $display("FAIL wr_seq[%0d] got=%b/%h/%h exp=1/%h/%h", i, instrValid, instrPc, instrByte, exp_pc[i], exp_pc[i][7:0]); end
      instrTake = 1'b1;
      step();
      instrTake = 1'b0;
    end
  endtask

  task automatic test_halt_reset;
    halt = 1'b1;
    step(); step(); step();
    memReady = 1'b0; loadPc = 1'b1; newPc = 16'h0100;
    step();
    loadPc = 1'b0; halt = 1'b0;
    step();
    checks++; if (memRead !== 1'b1 || memAddr !== 16'h0100) begin failures++; $display("FAIL hr_issue got=%b/%h exp=1/0100", memRead, memAddr); end
    halt = 1'b1;
    step(); step();
    checks++; if (memRead !== 1'b1 || memAddr !== 16'h0100 || instrValid !== 1'b0) begin
      failures++; $display("FAIL hr_hold got=%b/%h/%b exp=1/0100/0", memRead, memAddr, instrValid); end
    memReady = 1'b1;
    step();
    checks++; if (memRead !== 1'b0 || instrValid !== 1'b1 || instrPc !== 16'h0100 || instrByte !== 8'h00) begin
      failures++; $display("FAIL hr_complete got=%b/%b/%h/%h exp=0/1/0100/00", memRead, instrValid, instrPc, instrByte); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (memRead !== 1'b0) begin failures++; $display("FAIL hr_no_issue[%0d] got=%b exp=0", i, memRead); end
    end
    memReady = 1'b0; halt = 1'b0;
    step();
    checks++; if (memRead !== 1'b1 || memAddr !== 16'h0101) begin failures++; $display("FAIL hr_resume got=%b/%h exp=1/0101", memRead, memAddr); end
    #3 nReset = 1'b0;
    #1;
    checks++; if (memRead !== 1'b0 || instrValid !== 1'b0) begin failures++; $display("FAIL hr_async_rst got=%b/%b exp=0/0", memRead, instrValid); end
    checks++; if (memAddr !== 16'h0000 || instrPc !== 16'h0000) begin failures++; $display("FAIL hr_rst_addr got=%h/%h exp=0000/0000", memAddr, instrPc); end
  endtask

  task automatic test_one_wait;
    logic [15:0] e;
    logic [15:0] a;
    e = 16'h0000;
    step();
    nReset = 1'b1; instrTake = 1'b1; halt = 1'b0;
    for (int s = 0; s < 13; s++) begin
      if (s >= 1) begin
        a = 16'((s - 1) / 2);
        checks++; if (memRead !== 1'b1 || memAddr !== a) begin failures++; $display("FAIL ow_addr[%0d] got=%b/%h exp=1/%h", s, memRead, memAddr, a); end
      end
      if (instrValid === 1'b1) begin
        checks++; if (instrPc !== e || instrByte !== e[7:0]) begin failures++; $display("FAIL ow_seq[%0d] got=%h/%h exp=%h/%h", s, instrPc, instrByte, e, e[7:0]); end
        e = e + 16'd1;
      end
      memReady = (s % 2 == 0);
      step();
    end
    checks++; if (e !== 16'd5) begin failures++; $display("FAIL ow_count got=%0d exp=5", e); end
    instrTake = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_zero_wait();
    test_full_pop();
    test_discard();
    test_wrap();
    test_halt_reset();
    test_one_wait();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
